// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared FPU definitions. Contains the single-precision field
//                layout, the canonical special-value encodings, the operand
//                classifier and the state encoding of the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // IEEE-754 single-precision field layout.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    localparam logic [31:0] QNAN    = 32'h7fc00000;
    localparam logic [31:0] POS_INF = 32'h7f800000;
    localparam int          BIAS    = 127;

    // Control states of fdiv_iter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } fdiv_state_t;

    // Operand classes. Denormals fall into CLS_ZERO because the FPU flushes
    // them to zero on input.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_INF  = 2'd1,
        CLS_NAN  = 2'd2,
        CLS_NORM = 2'd3
    } fclass_t;

    function automatic fclass_t classify(input float_t f);
        fclass_t c;
        if (f.exp == 8'h00) begin
            c = CLS_ZERO;
        end else if (f.exp == 8'hff) begin
            c = (f.man == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_round_pack
//  Description : Combinational normalise, round-to-nearest-even and pack for
//                a 26-bit raw quotient (24 significand bits + guard + round).
//                Flushes results below the normal range to signed zero and
//                saturates results above it to signed infinity.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_q      [25:0]  raw quotient, value in (2^24, 2^26)
//    i_sticky         any nonzero bits below i_q[0]
//    i_exp    [9:0]   signed biased exponent assuming i_q[25] is the MSB
//    i_sign           result sign
//    o_y      [31:0]  packed single-precision result
//    o_ovf            result saturated to infinity
//    o_udf            nonzero result flushed to zero
// ============================================================================
module fdiv_round_pack (
    input  logic              i_sign,
    input  logic [25:0]       i_q,
    input  logic              i_sticky,
    input  logic signed [9:0] i_exp,
    output logic [31:0]       o_y,
    output logic              o_ovf,
    output logic              o_udf
);

    logic [22:0]        w_man;
    logic [22:0]        w_man_rnd;
    logic               w_guard;
    logic               w_stk;
    logic               w_rnd;
    logic [23:0]        w_sum;
    logic signed [10:0] w_exp;

    always_comb begin
        w_man     = 23'd0;
        w_man_rnd = 23'd0;
        w_guard   = 1'b0;
        w_stk     = 1'b0;
        w_rnd     = 1'b0;
        w_sum     = 24'd0;
        w_exp     = $signed({i_exp[9], i_exp});
        o_y       = 32'd0;
        o_ovf     = 1'b0;
        o_udf     = 1'b0;

        // Quotient of two significands in [1,2) lies in (0.5,2); pick the
        // 24 bits starting at the leading one and keep the rest for rounding.
        if (i_q[25]) begin
            w_man   = i_q[24:2];
            w_guard = i_q[1];
            w_stk   = i_sticky | i_q[0];
        end else begin
            w_man   = i_q[23:1];
            w_guard = i_q[0];
            w_stk   = i_sticky;
            w_exp   = w_exp - 11'sd1;
        end

        w_rnd = w_guard & (w_stk | w_man[0]);
        w_sum = {1'b0, w_man} + {23'd0, w_rnd};

        // Carry out of the fraction means the significand rounded up to 2.0.
        if (w_sum[23]) begin
            w_exp     = w_exp + 11'sd1;
            w_man_rnd = 23'd0;
        end else begin
            w_man_rnd = w_sum[22:0];
        end

        if (w_exp >= 11'sd255) begin
            o_y   = {i_sign, 8'hff, 23'd0};
            o_ovf = 1'b1;
        end else if (w_exp <= 11'sd0) begin
            o_y   = {i_sign, 31'd0};
            o_udf = 1'b1;
        end else begin
            o_y   = {i_sign, w_exp[7:0], w_man_rnd};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_iter
//  Description : Sequential IEEE-754 single-precision divider y = x1 / x2.
//                Restoring radix-2 core producing one quotient bit per cycle,
//                followed by one round/pack cycle. Denormal inputs are
//                flushed to zero and no denormal results are produced.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst          clock, synchronous active-high reset
//    in_valid/in_ready operand handshake (x1 dividend, x2 divisor)
//    out_valid/out_ready result handshake
//    y    [31:0]       quotient
//    ovf               finite operands produced an infinite result
//    udf               nonzero result flushed to zero
//
//  Timing: operands are registered on the accept edge. The next cycle
//  classifies them; specials finish there (result one cycle after accept),
//  otherwise the datapath is loaded and QBITS iteration cycles plus one
//  round cycle follow (result QBITS+2 cycles after accept).
// ============================================================================
module fdiv_iter #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        udf
);

    import fpu_pkg::*;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    fdiv_state_t        r_state;
    fdiv_state_t        w_next;

    float_t             r_a;
    float_t             r_b;
    logic               r_prep;      // first DIV cycle: classify and load
    logic [24:0]        r_rem;       // partial remainder
    logic [23:0]        r_mb;        // divisor significand
    logic [QBITS-1:0]   r_q;         // quotient bits, MSB first
    logic [4:0]         r_cnt;       // quotient bits produced so far
    logic signed [9:0]  r_exp;
    logic               r_sign;

    logic [31:0]        r_y;
    logic               r_ovf;
    logic               r_udf;
    logic               r_in_ready;
    logic               r_out_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    fclass_t            w_cls_a;
    fclass_t            w_cls_b;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_spec_y;
    logic signed [9:0]  w_exp0;

    logic               w_ge;
    logic [24:0]        w_diff;
    logic [24:0]        w_rem_sel;
    logic [24:0]        w_rem_next;
    logic               w_last;
    logic               w_sticky;

    logic [31:0]        w_rp_y;
    logic               w_rp_ovf;
    logic               w_rp_udf;

    // Special-operand resolution on the registered operands.
    always_comb begin
        w_cls_a   = classify(r_a);
        w_cls_b   = classify(r_b);
        w_sign    = r_a.sign ^ r_b.sign;
        w_special = 1'b1;
        w_spec_y  = QNAN;

        if ((w_cls_a == CLS_NAN) || (w_cls_b == CLS_NAN) ||
            ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_ZERO)) ||
            ((w_cls_a == CLS_INF)  && (w_cls_b == CLS_INF))) begin
            w_spec_y = QNAN;
        end else if ((w_cls_a == CLS_INF) || (w_cls_b == CLS_ZERO)) begin
            w_spec_y = {w_sign, POS_INF[30:0]};
        end else if ((w_cls_a == CLS_ZERO) || (w_cls_b == CLS_INF)) begin
            w_spec_y = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end

        w_exp0 = $signed({2'b00, r_a.exp}) - $signed({2'b00, r_b.exp})
               + $signed(10'(BIAS));
    end

    // One restoring step. The remainder stays below 2*mb < 2^25, so the
    // 25-bit shift never loses a set bit.
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_diff     = r_rem - {1'b0, r_mb};
        w_rem_sel  = w_ge ? w_diff : r_rem;
        w_rem_next = w_rem_sel << 1;
        w_last     = (r_cnt == 5'(QBITS - 1));
        w_sticky   = |r_rem;
    end

    fdiv_round_pack u_round_pack (
        .i_sign   (r_sign),
        .i_q      (r_q),
        .i_sticky (w_sticky),
        .i_exp    (r_exp),
        .o_y      (w_rp_y),
        .o_ovf    (w_rp_ovf),
        .o_udf    (w_rp_udf)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_next = ST_DIV;
                end
            end
            ST_DIV: begin
                if (r_prep) begin
                    if (w_special) begin
                        w_next = ST_DONE;
                    end
                end else if (w_last) begin
                    w_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_prep      <= 1'b0;
            r_rem       <= '0;
            r_mb        <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == ST_IDLE);
            r_out_valid <= (w_next == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a    <= x1;
                        r_b    <= x2;
                        r_prep <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (r_prep) begin
                        r_prep <= 1'b0;
                        if (w_special) begin
                            r_y   <= w_spec_y;
                            r_ovf <= 1'b0;
                            r_udf <= 1'b0;
                        end else begin
                            r_rem  <= {2'b01, r_a.man};
                            r_mb   <= {1'b1, r_b.man};
                            r_q    <= '0;
                            r_cnt  <= '0;
                            r_exp  <= w_exp0;
                            r_sign <= w_sign;
                        end
                    end else begin
                        r_q   <= {r_q[QBITS-2:0], w_ge};
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_ROUND: begin
                    r_y   <= w_rp_y;
                    r_ovf <= w_rp_ovf;
                    r_udf <= w_rp_udf;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign ovf       = r_ovf;
    assign udf       = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdiv_iter
//  Description : Self-checking bench for fdiv_iter: directed vector table,
//                backpressure and mid-operation reset sequences, and random
//                operands checked against an exact-arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic        udf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fdiv_iter #(.QBITS(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .udf       (udf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        udf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient with 39 fractional bits, then
    // round-to-nearest-even on the value, flush/saturate on the exponent.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] ry, output logic rovf,
                                    output logic rudf, output int rlat);
        int ea, eb, e, sh;
        bit za, zb, ia, ib, na, nb, s;
        longint unsigned ma, mb, num, qq, rr, sig, drop, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        s  = a[31] ^ b[31];
        rovf = 1'b0;
        rudf = 1'b0;
        rlat = 1;
        if (na || nb || (za && zb) || (ia && ib)) begin
            ry = 32'h7fc00000;
        end else if (ia || zb) begin
            ry = {s, 8'hff, 23'd0};
        end else if (za || ib) begin
            ry = {s, 31'd0};
        end else begin
            rlat = 28;
            ma   = {40'd0, 1'b1, a[22:0]};
            mb   = {40'd0, 1'b1, b[22:0]};
            num  = ma << 39;
            qq   = num / mb;
            rr   = num % mb;
            e    = ea - eb + 127;
            if (qq >= (64'd1 << 39)) begin
                sh = 16;
            end else begin
                sh = 15;
                e  = e - 1;
            end
            sig  = qq >> sh;
            drop = qq & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if ((drop > half) || ((drop == half) && ((rr != 0) || sig[0]))) begin
                sig = sig + 64'd1;
            end
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                e   = e + 1;
            end
            if (e >= 255) begin
                ry   = {s, 8'hff, 23'd0};
                rovf = 1'b1;
            end else if (e <= 0) begin
                ry   = {s, 31'd0};
                rudf = 1'b1;
            end else begin
                ry = {s, e[7:0], sig[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k < 10)       v[30:23] = 8'($urandom_range(100, 154));
        else if (k == 10) v[30:23] = 8'h00;
        else if (k == 11) v[30:23] = 8'hff;
        else if (k == 12) v[30:0]  = 31'h7f800000;
        else if (k == 13) v[30:23] = 8'($urandom_range(1, 20));
        else              v[30:23] = 8'($urandom_range(230, 254));
        return v;
    endfunction

    // Presents one operand pair and waits (bounded) for out_valid; lat is the
    // number of clock edges from the accept edge to the one raising out_valid.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready before accept", 32'(in_ready), 32'd1);
        x1       = a;
        x2       = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ry, output logic ro, output logic ru,
                         output int lat);
        start_op(a, b, lat);
        ry = y;
        ro = ovf;
        ru = udf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ry, ey, a, b, hy;
        logic        ro, ru, eo, eu, ho, hu;
        int          lat, el;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = 32'd0;
        x2        = 32'd0;

        vecs.push_back('{32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h40c00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h3f800000, 32'h40400000, 32'h3eaaaaab, 1'b0, 1'b0, 28});
        vecs.push_back('{32'hbf800000, 32'h40400000, 32'hbeaaaaab, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h40490fdb, 32'h40000000, 32'h3fc90fdb, 1'b0, 1'b0, 28});
        vecs.push_back('{32'hc0490fdb, 32'h40000000, 32'hbfc90fdb, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h7f000000, 32'h3e800000, 32'h7f800000, 1'b1, 1'b0, 28});
        vecs.push_back('{32'h00800000, 32'h4b000000, 32'h00000000, 1'b0, 1'b1, 28});
        vecs.push_back('{32'h3f800000, 32'h00000000, 32'h7f800000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hc0000000, 32'h80000000, 32'h7f800000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7fc00000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7f800000, 32'h7f800000, 32'h7fc00000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000000, 32'h3f800000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000001, 32'h3f800000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hbf800000, 32'h7f800000, 32'h80000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hff800000, 32'h40000000, 32'hff800000, 1'b0, 1'b0, 1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset y",         y,              32'd0);
        chk("reset ovf",       32'(ovf),       32'd0);
        chk("reset udf",       32'(udf),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].a, vecs[i].b, ry, ro, ru, lat);
            chk($sformatf("vec%0d y", i),   ry,       vecs[i].y);
            chk($sformatf("vec%0d ovf", i), 32'(ro),  32'(vecs[i].ovf));
            chk($sformatf("vec%0d udf", i), 32'(ru),  32'(vecs[i].udf));
            chk($sformatf("vec%0d lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d in_ready after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held while out_ready is low, new requests ignored
        start_op(32'h3f800000, 32'h40400000, lat);
        chk("bp lat", 32'(lat), 32'd28);
        hy = y;
        ho = ovf;
        hu = udf;
        chk("bp y", hy, 32'h3eaaaaab);
        for (int c = 0; c < 10; c++) begin
            x1       = 32'h40000000;
            x2       = 32'h3f800000;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d y", c),         y,               hy);
            chk($sformatf("bp%0d ovf", c),       32'(ovf),        32'(ho));
            chk($sformatf("bp%0d udf", c),       32'(udf),        32'(hu));
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid),  32'd1);
            chk($sformatf("bp%0d in_ready", c),  32'(in_ready),   32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready",  32'(in_ready),  32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp no ghost result", 32'(out_valid), 32'd0);

        // Reset in the middle of an iteration
        x1       = 32'h7f000000;
        x2       = 32'h3e800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid-div in_ready",  32'(in_ready),  32'd0);
        chk("mid-div out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort in_ready",  32'(in_ready),  32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        do_op(32'h3f800000, 32'h40400000, ry, ro, ru, lat);
        chk("post-abort y",   ry,       32'h3eaaaaab);
        chk("post-abort ovf", 32'(ro),  32'd0);
        chk("post-abort lat", 32'(lat), 32'd28);

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            ref_div(a, b, ey, eo, eu, el);
            do_op(a, b, ry, ro, ru, lat);
            if (ry !== ey)
                $display("  operands %08h / %08h", a, b);
            chk($sformatf("rnd%0d y", i),   ry,       ey);
            chk($sformatf("rnd%0d ovf", i), 32'(ro),  32'(eo));
            chk($sformatf("rnd%0d udf", i), 32'(ru),  32'(eu));
            chk($sformatf("rnd%0d lat", i), 32'(lat), 32'(el));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
Sequential IEEE-754 single-precision divider y = x1 / x2, the inverse operation of the combinational fmul.
- Restoring radix-2 datapath: one quotient bit per cycle, then round-to-nearest-even and pack.
- Valid/ready handshake on input and output; shares the FPU's flush-to-zero conventions and the ovf/udf flag semantics of fmul.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand + guard + round; remainder gives sticky.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- x1  input  32  dividend
- x2  input  32  divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- y  output  32  quotient
- ovf  output  1  finite operands gave an infinite result
- udf  output  1  nonzero result flushed to zero

Behaviour:
Reset and states
- Reset (rst=1 at a clk edge) forces IDLE from any state, aborting any operation in flight: in_ready=1, out_valid=0, y=0, ovf=0, udf=0.
- States: IDLE, DIV, ROUND, DONE.

IDLE
- in_ready=1. An operation is accepted when in_valid & in_ready; x1/x2 are registered on that edge.
- Special operands go directly to DONE (out_valid one cycle after accept); all others go to DIV.

Operand rules
- Exponent 0 means zero; denormal inputs are flushed to zero.
- Result sign is s1^s2, except NaN.
- NaN operand, 0/0 or inf/inf gives y=32'h7fc00000.
- Finite nonzero / 0 and inf / (finite or 0) give signed inf. For these, ovf=0 and udf=0.
- 0 / (nonzero or inf) and finite / inf give signed zero, udf=0.

DIV
- Load ma={1,m1}, mb={1,m2}; e = e1 - e2 + 127, as a 10-bit signed value.
- Iterate QBITS cycles with a 5-bit counter; each cycle produces the next bit of q = floor(ma*2^25 / mb).
- Partial remainder is 25 bits. Final remainder !=0 sets sticky.
- After the last bit, go to ROUND.

ROUND (1 cycle)
- If q[25]=1: mantissa=q[24:2], guard=q[1], sticky|=q[0].
- Else: mantissa=q[23:1], guard=q[0], e=e-1.
- Round up when guard & (sticky | mantissa[0]). A mantissa carry-out increments e and zeroes the mantissa.
- e>=255 gives signed inf, ovf=1.
- e<=0 gives signed zero, udf=1 (no denormal outputs).
- Go to DONE.

DONE
- out_valid=1; y, ovf and udf stay stable until out_valid & out_ready, then return to IDLE.
- in_ready=0 in DIV, ROUND and DONE; there is no overlap of operations.
- Latency, normal operands: accept edge to out_valid = QBITS+2 = 28 cycles. Special operands: 1 cycle.
- Outputs are registered. y/ovf/udf values outside DONE are don't-care but must not be X after reset.

Decomposition:
- Shared package fpu_pkg:
  - float fields typedef {sign, exp[7:0], man[22:0]}
  - constants QNAN=32'h7fc00000, POS_INF=32'h7f800000, BIAS=127
  - state enum for fdiv_iter
  - classify function returning zero/inf/nan/normal
- One sub-module, fdiv_round_pack: combinational normalise, round-to-nearest-even and pack, taking q, sticky and e; returns y, ovf, udf. It is reusable by a future pipelined fsqrt.

Test Plan:
- 3f800000 / 3f800000, out_ready=1 -> y=3f800000, ovf=0, udf=0, out_valid exactly 28 cycles after accept; 40c00000 / 40400000 -> 40000000.
- 3f800000 / 40400000 (1/3) -> y=3eaaaaab, which exercises the round-up path; bf800000 / 40400000 -> beaaaaab.
- 7f000000 / 3e800000 -> y=7f800000, ovf=1; 00800000 / 4b000000 -> y=00000000, udf=1.
- Specials:
  - 3f800000 / 00000000 -> 7f800000, ovf=0, latency 1.
  - 00000000 / 00000000 -> 7fc00000.
  - 7f800000 / 7f800000 -> 7fc00000.
  - 00000000 / 3f800000 -> 00000000, udf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> y and flags stable, in_ready=0 throughout, new in_valid ignored; after the out_ready pulse, in_ready=1 next cycle.
- Reset mid-DIV, asserted 10 cycles after accept -> next edge gives IDLE with out_valid=0 and in_ready=1. A following 1/3 request yields the correct 3eaaaaab, so no stale remainder is carried over.
